// File: rtl/sgnmag_to_bcd_if.sv
// Request/response bundle between a sign-magnitude source and the BCD converter.
// start is a request taken on any rising edge where busy is low; done is a one-cycle response pulse.
interface sgnmag_to_bcd_if #(
  parameter int DATA_W = 17,
  parameter int NDIG   = 6
);
  logic              start;
  logic              sign_in;
  logic [DATA_W-1:0] mag_in;
  logic              busy;
  logic              done;
  logic              sign_out;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   blank_out;

  modport master (
    output start, sign_in, mag_in,
    input  busy, done, sign_out, bcd_out, blank_out
  );

  modport slave (
    input  start, sign_in, mag_in,
    output busy, done, sign_out, bcd_out, blank_out
  );
endinterface

// File: rtl/sgnmag_to_bcd.sv
// Sequential shift-add-3 converter from sign-magnitude to packed BCD with sign flag
// and leading-zero blank mask; one magnitude bit is consumed per clock.
module sgnmag_to_bcd #(
  parameter int DATA_W = 17,
  parameter int NDIG   = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  sgnmag_to_bcd_if.slave      bus,
  output logic                state_dbg
);
  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [NDIG-1:0] BLANK_RST = {{(NDIG-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              last;
  logic              sign_r;
  logic [DATA_W-1:0] mag_r;
  logic [BW-1:0]     work;
  logic [BW-1:0]     work_adj;
  logic [BW-1:0]     work_shift;
  logic [CW-1:0]     cnt;
  logic [NDIG-1:0]   blank_nxt;
  logic              seen_nz;
  logic              unused_msb;

  // Digits >= 5 would become >= 10 after doubling, so pre-add 3 to force the carry.
  always_comb begin
    work_adj = work;
    for (int d = 0; d < NDIG; d++) begin
      if (work[4*d +: 4] >= 4'd5) work_adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
    end
    work_shift = {work_adj[BW-2:0], mag_r[DATA_W-1]};
  end

  // Top bit never carries for legal NDIG, it only exists as the shift-out position.
  assign unused_msb = work_adj[BW-1];

  // Scan from the most significant digit down; a digit blanks until a non-zero is seen.
  always_comb begin
    seen_nz   = 1'b0;
    blank_nxt = '0;
    for (int d = NDIG - 1; d >= 1; d--) begin
      seen_nz      = seen_nz | (work_shift[4*d +: 4] != 4'd0);
      blank_nxt[d] = ~seen_nz;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(DATA_W - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r        <= 1'b0;
      mag_r         <= '0;
      work          <= '0;
      cnt           <= '0;
      bus.done      <= 1'b0;
      bus.sign_out  <= 1'b0;
      bus.bcd_out   <= '0;
      bus.blank_out <= BLANK_RST;
    end else begin
      bus.done <= last;
      if (accept) begin
        sign_r <= bus.sign_in;
        mag_r  <= bus.mag_in;
        work   <= '0;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        work  <= work_shift;
        mag_r <= {mag_r[DATA_W-2:0], 1'b0};
        cnt   <= cnt + 1'b1;
      end
      if (last) begin
        bus.bcd_out   <= work_shift;
        bus.sign_out  <= sign_r & (work_shift != '0);
        bus.blank_out <= blank_nxt;
      end
    end
  end

  assign bus.busy  = (state == SHIFT);
  assign state_dbg = state;
endmodule

// File: tb/tb_sgnmag_to_bcd.sv
// Randomized and directed bench for sgnmag_to_bcd; results are scored against a
// decimal-arithmetic reference model through an expected queue.
module tb_sgnmag_to_bcd;
  localparam int DATA_W = 17;
  localparam int NDIG   = 6;
  localparam int W      = 1 + 4*NDIG + NDIG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic state_dbg;

  sgnmag_to_bcd_if #(.DATA_W(DATA_W), .NDIG(NDIG)) bus ();

  sgnmag_to_bcd #(.DATA_W(DATA_W), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Reference: decimal digits by division, blank where the value is below 10**i.
  function automatic logic [W-1:0] model(input logic s, input logic [DATA_W-1:0] m);
    int v;
    int p;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   blank;
    v = int'(m);
    bcd = '0;
    for (int i = 0; i < NDIG; i++) begin
      bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    blank = '0;
    p = 1;
    for (int i = 1; i < NDIG; i++) begin
      p = p * 10;
      blank[i] = (int'(m) < p);
    end
    return {s && (m != '0), bcd, blank};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      check("done_expected", 32'(exp_q.size() != 0), 32'd1);
      check("busy_low_at_done", 32'(bus.busy), 32'd0);
      if (exp_q.size() != 0)
        check("result", 32'({bus.sign_out, bus.bcd_out, bus.blank_out}), 32'(exp_q.pop_front()));
    end
  end

  task automatic issue(input logic s, input logic [DATA_W-1:0] m);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_before_start", 32'(bus.busy), 32'd0);
    bus.start   = 1'b1;
    bus.sign_in = s;
    bus.mag_in  = m;
    exp_q.push_back(model(s, m));
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.sign_in = 1'($urandom);
    bus.mag_in  = DATA_W'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("state_after_accept", 32'(state_dbg), 32'd1);
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.done && lat < 100);
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.sign_in = 1'b0;
    bus.mag_in  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_outputs", 32'({bus.sign_out, bus.bcd_out, bus.blank_out}), 32'({1'b0, 24'h0, 6'b111110}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Small negative, full-scale, negative zero.
    issue(1'b1, 17'd5);       wait_done(DATA_W);
    issue(1'b0, 17'h1FFFF);   wait_done(DATA_W);
    issue(1'b1, 17'd0);       wait_done(DATA_W);
    repeat (2) @(posedge clk); #1;

    // start while busy is ignored.
    issue(1'b1, 17'd7);
    repeat (5) @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.mag_in = 17'd8;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    check("busy_held", 32'(bus.busy), 32'd1);
    wait_done(DATA_W - 6);
    repeat (25) @(posedge clk); #1;

    // Back-to-back: second start presented while done is high.
    issue(1'b0, 17'd8);       wait_done(DATA_W);
    issue(1'b0, 17'd1000);    wait_done(DATA_W);
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of a conversion.
    issue(1'b0, 17'd12345);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_outputs", 32'({bus.sign_out, bus.bcd_out, bus.blank_out}), 32'({1'b0, 24'h0, 6'b111110}));
    rst_n = 1'b1;
    repeat (25) @(posedge clk); #1;
    issue(1'b1, 17'd12345);   wait_done(DATA_W);

    // Random mix, sometimes back-to-back.
    for (int t = 0; t < 40; t++) begin
      logic [DATA_W-1:0] m;
      case ($urandom_range(0, 3))
        0: m = DATA_W'($urandom_range(0, 131071));
        1: m = DATA_W'($urandom_range(0, 20));
        2: m = DATA_W'($urandom_range(99990, 100010));
        default: m = DATA_W'($urandom_range(131000, 131071));
      endcase
      issue(1'($urandom_range(0, 1)), m);
      wait_done(DATA_W);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk); #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
